// File: rtl/gray_updown_counter.sv
// gray_updown_counter: binary up/down counter with registered binary and Gray outputs, loadable in either encoding
// Ports: clk, rst_n (async active-low); en count enable; up direction (1 = +1);
//        load strobe with load_sel (0 = binary, 1 = Gray) and load_val;
//        bin_out / gray_out registered count; wrap one-cycle pulse after a wrapping step.
module gray_updown_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_sel,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap
);
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("gray_updown_counter: WIDTH must be in 2..32");
  end
  logic [WIDTH-1:0] cnt_q, cnt_d, gray_q, load_bin;
  logic             wrap_q, wrap_d;
  // Gray-to-binary is a prefix XOR running down from the MSB.
  always_comb begin
    load_bin = load_val;
    for (int i = WIDTH - 2; i >= 0; i--) load_bin[i] = load_bin[i+1] ^ load_val[i];
  end
  always_comb begin
    cnt_d  = load ? (load_sel ? load_bin : load_val)
           : en   ? (up ? cnt_q + 1'b1 : cnt_q - 1'b1)
           : cnt_q;
    wrap_d = !load && en && (up ? &cnt_q : ~|cnt_q);
  end
  // Gray is registered from the same next-state value so both outputs always agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gray_q <= cnt_d ^ (cnt_d >> 1);
      wrap_q <= wrap_d;
    end
  end
  assign bin_out  = cnt_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;
endmodule

// File: tb/tb_gray_updown_counter.sv
// tb_gray_updown_counter: scoreboard bench driving WIDTH=4 and WIDTH=8 counters with identical stimulus
module tb_gray_updown_counter;
  typedef struct {
    logic [7:0] b4, g4, b8, g8;
    logic       w4, w8;
  } exp_t;
  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0, load_sel = 1'b0;
  logic [7:0] load_val = '0;
  logic [3:0] bin4, gray4;
  logic [7:0] bin8, gray8;
  logic       wrap4, wrap8;
  exp_t       sb[$];
  int         checks = 0, failures = 0, m4 = 0, m8 = 0, wraps4 = 0, wraps8 = 0;

  always #5 clk = ~clk;

  gray_updown_counter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_sel(load_sel),
    .load_val(load_val[3:0]), .bin_out(bin4), .gray_out(gray4), .wrap(wrap4)
  );
  gray_updown_counter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_sel(load_sel),
    .load_val(load_val), .bin_out(bin8), .gray_out(gray8), .wrap(wrap8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int g2b(input int g);
    int b;
    b = 0;
    for (int k = 0; k < 32; k++) b = b ^ (g >> k);
    return b;
  endfunction

  task automatic step(input logic e, input logic u, input logic l, input logic s, input logic [7:0] v);
    exp_t       x;
    logic [3:0] pg4;
    logic [7:0] pg8;
    pg4 = gray4;
    pg8 = gray8;
    en = e; up = u; load = l; load_sel = s; load_val = v;
    if (l) begin
      m4 = s ? g2b(int'(v) & 15) & 15 : int'(v) & 15;
      m8 = s ? g2b(int'(v)) & 255 : int'(v);
      x.w4 = 1'b0;
      x.w8 = 1'b0;
    end else if (e) begin
      x.w4 = u ? (m4 == 15) : (m4 == 0);
      x.w8 = u ? (m8 == 255) : (m8 == 0);
      m4 = u ? (m4 + 1) & 15 : (m4 - 1) & 15;
      m8 = u ? (m8 + 1) & 255 : (m8 - 1) & 255;
    end else begin
      x.w4 = 1'b0;
      x.w8 = 1'b0;
    end
    x.b4 = 8'(m4);
    x.g4 = 8'(m4 ^ (m4 >> 1));
    x.b8 = 8'(m8);
    x.g8 = 8'(m8 ^ (m8 >> 1));
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("bin4", 32'(bin4), 32'(x.b4));
    chk("gray4", 32'(gray4), 32'(x.g4));
    chk("wrap4", 32'(wrap4), 32'(x.w4));
    chk("bin8", 32'(bin8), 32'(x.b8));
    chk("gray8", 32'(gray8), 32'(x.g8));
    chk("wrap8", 32'(wrap8), 32'(x.w8));
    if (e && !l) begin
      chk("gray4_onebit", $countones(pg4 ^ gray4), 1);
      chk("gray8_onebit", $countones(pg8 ^ gray8), 1);
    end
    wraps4 += int'(wrap4);
    wraps8 += int'(wrap8);
  endtask

  initial begin
    #12;
    chk("rst_bin4", 32'(bin4), 0);
    chk("rst_gray4", 32'(gray4), 0);
    chk("rst_wrap4", 32'(wrap4), 0);
    chk("rst_bin8", 32'(bin8), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) step(1, 1, 0, 0, 0);
    chk("pre_rst_bin4", 32'(bin4), 9);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_bin4", 32'(bin4), 0);
    chk("async_rst_gray4", 32'(gray4), 0);
    chk("async_rst_bin8", 32'(bin8), 0);
    m4 = 0;
    m8 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 0, 0, 0);
    chk("post_rst_bin4", 32'(bin4), 1);
    chk("post_rst_gray4", 32'(gray4), 32'b0001);
    step(0, 0, 1, 0, 0);
    wraps4 = 0;
    for (int i = 0; i < 16; i++) step(1, 1, 0, 0, 0);
    chk("sweep_end_bin4", 32'(bin4), 0);
    chk("sweep_end_gray4", 32'(gray4), 0);
    chk("sweep_end_wrap4", 32'(wrap4), 1);
    chk("sweep_wraps4", wraps4, 1);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("down_wrap_bin4", 32'(bin4), 15);
    chk("down_wrap_gray4", 32'(gray4), 32'b1000);
    chk("down_wrap_wrap4", 32'(wrap4), 1);
    step(1, 0, 0, 0, 0);
    chk("down_next_bin4", 32'(bin4), 14);
    chk("down_next_gray4", 32'(gray4), 32'b1001);
    chk("down_next_wrap4", 32'(wrap4), 0);
    step(0, 0, 1, 1, 8'b0000_1101);
    chk("gray_load_bin4", 32'(bin4), 9);
    chk("gray_load_gray4", 32'(gray4), 32'b1101);
    step(0, 0, 1, 0, 8'd6);
    chk("bin_load_bin4", 32'(bin4), 6);
    chk("bin_load_gray4", 32'(gray4), 32'b0101);
    step(1, 1, 1, 0, 8'd15);
    chk("prio_bin4", 32'(bin4), 15);
    chk("prio_wrap4", 32'(wrap4), 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
    chk("hold_bin4", 32'(bin4), 15);
    chk("hold_wrap4", 32'(wrap4), 0);
    step(1, 1, 0, 0, 0);
    chk("hold_step_bin4", 32'(bin4), 0);
    chk("hold_step_wrap4", 32'(wrap4), 1);
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 9) == 0),
           1'($urandom), 8'($urandom));
    step(0, 0, 1, 0, 0);
    wraps8 = 0;
    for (int i = 0; i < 257; i++) step(1, 1, 0, 0, 0);
    chk("sweep8_wraps", wraps8, 1);
    chk("sweep8_end_bin8", 32'(bin8), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gray_updown_counter.md
# gray_updown_counter

Parametrised up/down counter that holds its state in binary and presents it in both binary and reflected-Gray code every cycle. It can be loaded with a value given in either encoding, selected per load, so it generalises the team's combinational binary/Gray converter into a clocked, width-parametrised block. It sits wherever a Gray-coded position or pointer must cross into other logic while local arithmetic stays in binary, for example FIFO pointers or encoder position tracking.

## Interface
- `WIDTH`, default 4: counter width in bits; legal range 2 to 32.

- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: count enable; one step per cycle while high.
- `up`  in  1: direction; 1 = increment, 0 = decrement.
- `load`  in  1: synchronous load strobe.
- `load_sel`  in  1: encoding of `load_val`; 0 = binary, 1 = Gray.
- `load_val`  in  WIDTH: value to load.
- `bin_out`  out  WIDTH: registered count, binary.
- `gray_out`  out  WIDTH: registered count, Gray; always equals `bin_out ^ (bin_out >> 1)`.
- `wrap`  out  1: registered; high for exactly one cycle after a count step that wrapped.

## Operation
- Single internal state register `cnt[WIDTH-1:0]`, binary. All outputs are flops updated on the same edge as `cnt`; no combinational path from inputs to outputs.
- Per-edge priority is load, then en, then hold:
  - **Load** (`load`=1): `en` and `up` are ignored.
    - `load_sel`=0: `cnt <= load_val`.
    - `load_sel`=1: `cnt <= gray2bin(load_val)`, where `b[WIDTH-1] = g[WIDTH-1]` and `b[i] = b[i+1] ^ g[i]` for i descending (prefix XOR from the MSB).
    - `wrap <= 0`.
  - **Count** (`load`=0, `en`=1):
    - `up`=1: `cnt <= cnt + 1` modulo 2^WIDTH. `wrap <= 1` only when cnt was all-ones.
    - `up`=0: `cnt <= cnt - 1` modulo 2^WIDTH. `wrap <= 1` only when cnt was zero.
    - Otherwise `wrap <= 0`.
  - **Hold** (`load`=0, `en`=0): `cnt` unchanged; `wrap <= 0`.
- `bin_out <= next cnt` and `gray_out <= next cnt ^ (next cnt >> 1)`, computed from the same next-state value so the two outputs never disagree.
- Every count step changes exactly one bit of `gray_out`, including across wrap. A load may change any number of bits.
- Direction may change on any cycle. The step taken on a given edge uses the `up` value sampled at that edge.

## Timing
- Reset: `rst_n` low clears `cnt`, `bin_out`, `gray_out` and `wrap` to 0 immediately, without waiting for `clk`. Release is synchronous in effect: the first update happens on the first rising edge with `rst_n` high.
- Reset asserted mid-count overrides everything. After release, counting resumes from 0.
- Latency: inputs sampled at edge N appear on the outputs after edge N; load-to-output latency is 1 cycle.
- `wrap` is high in the cycle immediately following the wrapping edge. Sustained wrapping (WIDTH=2, continuous counting) gives one pulse per wrap, never a level.
- `load` and `en` high together: the load wins and `wrap` is 0.
- Out-of-range `WIDTH` is a build-time error, enforced by a generate-time check.

## Test plan
- **Reset:** assert `rst_n`=0 asynchronously mid-cycle while counting at 9 -> outputs go to 0 before the next `clk` edge. After release with `en`=1, `up`=1, the first edge gives `bin_out`=1, `gray_out`=4'b0001.
- **Up sweep, WIDTH=4:** `en`=1, `up`=1 for 17 cycles from 0 -> `bin_out` runs 0..15 then 0. `gray_out` runs 0000, 0001, 0011, 0010 … 1000, 0000. `wrap`=1 only in the cycle with `bin_out`=0 after 15. Checker confirms single-bit Gray change on every step.
- **Down wrap:** from 0 with `up`=0, `en`=1 -> `bin_out`=15, `gray_out`=4'b1000, `wrap`=1. The next step gives 14 / 4'b1001 and `wrap`=0.
- **Gray load:** `load`=1, `load_sel`=1, `load_val`=4'b1101 -> `bin_out`=9 (4'b1001), `gray_out`=4'b1101.
- **Binary load:** `load_sel`=0, `load_val`=6 -> `bin_out`=6, `gray_out`=4'b0101.
- **Priority and hold:** `load`=1 and `en`=1 together with binary `load_val`=15 -> `bin_out`=15, `wrap`=0. Then `en`=0 for 5 cycles -> outputs hold at 15 and `wrap` stays 0. Then one up-step -> `bin_out`=0, `wrap`=1.
- **WIDTH=8 regression:** repeat the up sweep for 257 cycles -> exactly one `wrap` pulse, no Gray multi-bit change.
